stk_rob: RTL

- Host-facing front end for the stack engine `stk`, placed directly upstream and downstream of it.
- Accepts host commands on a valid/ready handshake and allocates each one a 3-bit tag.
- Issues tagged commands to `stk`, collects `stk` responses by tag, and returns them to the host strictly in command-acceptance order.
- `stk` has no backpressure, so this block is the only place flow control exists.

---
 rtl/std_pkg.sv | 11 +
 rtl/stk_pkg.sv | 15 +
 rtl/stk_rob_ptr.sv | 51 +++++
 rtl/stk_rob.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/std_pkg.sv
// rtl/std_pkg.sv - opcode type shared by the host front end and the stack engine.
package std_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_PEEK = 2'd2,
        OP_CLR  = 2'd3
    } opcode_t;

endpackage

// File: rtl/stk_pkg.sv
// rtl/stk_pkg.sv - tag, payload and reorder-buffer entry types for the stk front end.
package stk_pkg;

    localparam int N_TAGS_MAX = 8;

    typedef logic [2:0]   stk_id_t;
    typedef logic [127:0] stk_dat_t;

    typedef struct packed {
        logic     alloc;
        logic     done;
        stk_dat_t dat;
    } rob_entry_t;

endpackage

// File: rtl/stk_rob_ptr.sv
// rtl/stk_rob_ptr.sv - wrapping head/tail pointer pair with occupancy counter.
module stk_rob_ptr #(
    parameter int N_TAGS = 8,
    localparam int PW = $clog2(N_TAGS)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          inc_head_i,
    input  logic          inc_tail_i,
    output logic [PW-1:0] head_o,
    output logic [PW-1:0] tail_o,
    output logic [PW:0]   cnt_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   cnt_q, cnt_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        head_d = inc_head_i ? head_q + 1'b1 : head_q;
        tail_d = inc_tail_i ? tail_q + 1'b1 : tail_q;
        cnt_d  = cnt_q;
        case ({inc_tail_i, inc_head_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q == (PW+1)'(N_TAGS));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/stk_rob.sv
// rtl/stk_rob.sv - tag-allocating reorder buffer in front of stk; STK_ROB_ERR_EN enables sticky spurious-response flag.
module stk_rob
    import std_pkg::*;
    import stk_pkg::*;
#(
    parameter int N_TAGS = 8,
    parameter int W_DAT  = 128
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             i_req_vld,
    output logic             o_req_rdy,
    input  opcode_t          i_req_opcode,
    input  logic [W_DAT-1:0] i_req_dat,
    output logic             o_cmd_vld,
    output opcode_t          o_cmd_opcode,
    output logic [2:0]       o_cmd_id,
    output logic [W_DAT-1:0] o_cmd_dat,
    input  logic             i_rsp_vld,
    input  logic [2:0]       i_rsp_id,
    input  logic [W_DAT-1:0] i_rsp_dat,
    output logic             o_rsp_vld,
    input  logic             i_rsp_rdy,
    output logic [W_DAT-1:0] o_rsp_dat,
    output logic             o_err
);

    localparam int PW = $clog2(N_TAGS);

    logic [PW-1:0]    head, tail;
    logic [PW:0]      cnt;
    logic             full, empty;

    logic [N_TAGS-1:0] alloc_q, alloc_d;
    logic [N_TAGS-1:0] done_q, done_d;
    logic [W_DAT-1:0]  dat_q [N_TAGS];

    logic             o_cmd_vld_q;
    opcode_t          o_cmd_opcode_q;
    stk_id_t          o_cmd_id_q;
    logic [W_DAT-1:0] o_cmd_dat_q;

    logic          accept, retire, rsp_wr, id_ok;
    logic [PW-1:0] rsp_idx;

    stk_rob_ptr #(.N_TAGS(N_TAGS)) u_ptr (
        .clk        (clk),
        .arst_n     (arst_n),
        .inc_head_i (retire),
        .inc_tail_i (accept),
        .head_o     (head),
        .tail_o     (tail),
        .cnt_o      (cnt),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign o_req_rdy = !full;
    assign accept    = i_req_vld && !full;
    assign o_rsp_vld = alloc_q[head] && done_q[head] && !empty;
    assign retire    = o_rsp_vld && i_rsp_rdy;
    assign o_rsp_dat = o_rsp_vld ? dat_q[head] : '0;

    // Tags beyond the configured depth never match an entry.
    assign id_ok   = (32'(i_rsp_id) < N_TAGS);
    assign rsp_idx = i_rsp_id[PW-1:0];
    assign rsp_wr  = i_rsp_vld && id_ok && alloc_q[rsp_idx] && !done_q[rsp_idx];

    // Head and tail only coincide when empty or full, so retire and accept never hit the same entry.
    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        if (retire) begin
            alloc_d[head] = 1'b0;
            done_d[head]  = 1'b0;
        end
        if (rsp_wr) begin
            done_d[rsp_idx] = 1'b1;
        end
        if (accept) begin
            alloc_d[tail] = 1'b1;
            done_d[tail]  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            alloc_q        <= '0;
            done_q         <= '0;
            o_cmd_vld_q    <= 1'b0;
            o_cmd_opcode_q <= OP_PUSH;
            o_cmd_id_q     <= '0;
            o_cmd_dat_q    <= '0;
        end else begin
            alloc_q     <= alloc_d;
            done_q      <= done_d;
            o_cmd_vld_q <= accept;
            if (accept) begin
                o_cmd_opcode_q <= i_req_opcode;
                o_cmd_id_q     <= stk_id_t'(tail);
                o_cmd_dat_q    <= i_req_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_wr) begin
            dat_q[rsp_idx] <= i_rsp_dat;
        end
    end

    assign o_cmd_vld    = o_cmd_vld_q;
    assign o_cmd_opcode = o_cmd_opcode_q;
    assign o_cmd_id     = o_cmd_id_q;
    assign o_cmd_dat    = o_cmd_dat_q;

`ifdef STK_ROB_ERR_EN
    logic spurious;
    logic err_q;

    assign spurious = i_rsp_vld && !rsp_wr;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            err_q <= 1'b0;
        end else if (spurious) begin
            err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arst_n) begin
            assert (!spurious) else $error("stk_rob: spurious response id %0d", i_rsp_id);
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
